// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU path vs. buffered long-latency results,
// with an anti-starvation override and a pending-destination scoreboard for issue stalls.
module regfile_writeback_arbiter #(
   parameter int REG_NUMBER         = 32,
   parameter int REG_WIDTH          = 32,
   parameter int REG_ADDR_WIDTH     = $clog2(REG_NUMBER),
   parameter int FIFO_DEPTH         = 4,
   parameter int MAX_STALL          = 3,
   parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0] alu_wb_addr,
   input  logic [REG_WIDTH-1:0]      alu_wb_data,
   output logic                      alu_stall,
   input  logic                      lu_valid,
   output logic                      lu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] lu_addr,
   input  logic [REG_WIDTH-1:0]      lu_data,
   input  logic                      issue_valid,
   input  logic [REG_ADDR_WIDTH-1:0] issue_addr,
   output logic [REG_NUMBER-1:0]     pending_mask,
   output logic                      write_enable,
   output logic [REG_ADDR_WIDTH-1:0] write_reg_addr,
   output logic [REG_WIDTH-1:0]      write_data
);

   localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic [REG_WIDTH-1:0]      data;
   } wb_req_t;

   wb_req_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [STV_W-1:0]    starve_cnt;
   logic                empty, full, push, pop, force_pop, alu_win, win, drop;
   wb_req_t             head, sel;
   logic [REG_NUMBER-1:0] pending_nxt;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign lu_ready  = !full;
   assign head      = fifo_mem[rd_ptr];

   // Arbitration depends only on registered state plus alu_wb_valid; alu_stall is state-only.
   assign force_pop = (starve_cnt == STV_W'(MAX_STALL)) && !empty;
   assign alu_win   = !force_pop && alu_wb_valid;
   assign pop       = force_pop || (!alu_wb_valid && !empty);
   assign push      = lu_valid && lu_ready;
   assign alu_stall = force_pop;
   assign win       = pop || alu_win;

   always_comb begin
      sel.addr = alu_wb_addr;
      sel.data = alu_wb_data;
      if (pop) sel = head;
   end

   assign drop = ZERO_REG_HARDWIRED && (sel.addr == '0);

   always_comb begin
      pending_nxt = pending_mask;
      if (pop) pending_nxt[head.addr] = 1'b0;
      // Set after clear so a same-cycle reissue of the popped register stays pending.
      if (issue_valid && !(ZERO_REG_HARDWIRED && (issue_addr == '0)))
         pending_nxt[issue_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{addr: lu_addr, data: lu_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         starve_cnt     <= '0;
         pending_mask   <= '0;
         write_enable   <= 1'b0;
         write_reg_addr <= '0;
         write_data     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (pop || empty)
            starve_cnt <= '0;
         else if (alu_win && (starve_cnt != STV_W'(MAX_STALL)))
            starve_cnt <= starve_cnt + STV_W'(1);

         pending_mask <= pending_nxt;

         write_enable <= win && !drop;
         if (win) begin
            write_reg_addr <= sel.addr;
            write_data     <= sel.data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: expected writes are queued by the stimulus,
// a negedge monitor pops and compares every observed register-file write.
module tb_regfile_writeback_arbiter;

   logic        clk, rst;
   logic        alu_wb_valid, alu_stall, lu_valid, lu_ready, issue_valid;
   logic [4:0]  alu_wb_addr, lu_addr, issue_addr, write_reg_addr;
   logic [31:0] alu_wb_data, lu_data, write_data, pending_mask;
   logic        write_enable;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   wb_t exp_q[$];
   wb_t mon_e;
   int  n_cmp = 0;
   int  n_err = 0;

   regfile_writeback_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
      .alu_stall(alu_stall),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .pending_mask(pending_mask),
      .write_enable(write_enable), .write_reg_addr(write_reg_addr), .write_data(write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wb_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
      alu_wb_valid = v; alu_wb_addr = a; alu_wb_data = d;
   endtask

   task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
      lu_valid = v; lu_addr = a; lu_data = d;
   endtask

   initial begin
      rst = 1'b1;
      alu(1'b0, 5'd0, 32'h0);
      lu(1'b0, 5'd0, 32'h0);
      issue_valid = 1'b0; issue_addr = 5'd0;

      fork
         forever begin
            @(negedge clk);
            if (write_enable === 1'b1) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                           write_reg_addr, write_data);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (write_reg_addr !== mon_e.addr || write_data !== mon_e.data) begin
                     n_err++;
                     $display("FAIL wb_order: got addr=%0d data=%h, required addr=%0d data=%h",
                              write_reg_addr, write_data, mon_e.addr, mon_e.data);
                  end
               end
            end
         end
      join_none

      // Reset and idle
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rst_lu_ready", {31'b0, lu_ready}, 32'd1);
         chk("rst_alu_stall", {31'b0, alu_stall}, 32'd0);
         chk("rst_we", {31'b0, write_enable}, 32'd0);
         chk("rst_pending", pending_mask, 32'h0);
         tick();
      end

      // ALU only, then x0 drop
      alu(1'b1, 5'd5, 32'hDEADBEEF); expect_wr(5'd5, 32'hDEADBEEF);
      tick();
      alu(1'b1, 5'd0, 32'h55);
      chk("alu_we", {31'b0, write_enable}, 32'd1);
      chk("alu_addr", {27'b0, write_reg_addr}, 32'd5);
      chk("alu_data", write_data, 32'hDEADBEEF);
      tick();
      alu(1'b0, 5'd0, 32'h0);
      chk("alu_x0_we", {31'b0, write_enable}, 32'd0);
      tick();

      // Starvation: one buffered result, ALU busy every cycle
      lu(1'b1, 5'd7, 32'h11);
      tick();
      lu(1'b0, 5'd0, 32'h0);
      chk("no_fallthrough_we", {31'b0, write_enable}, 32'd0);
      chk("starve_c1_stall", {31'b0, alu_stall}, 32'd0);
      alu(1'b1, 5'd1, 32'h101); expect_wr(5'd1, 32'h101); tick();
      chk("starve_c2_stall", {31'b0, alu_stall}, 32'd0);
      alu(1'b1, 5'd2, 32'h102); expect_wr(5'd2, 32'h102); tick();
      chk("starve_c3_stall", {31'b0, alu_stall}, 32'd0);
      alu(1'b1, 5'd3, 32'h103); expect_wr(5'd3, 32'h103); tick();
      chk("starve_force_stall", {31'b0, alu_stall}, 32'd1);
      alu(1'b1, 5'd4, 32'h104); expect_wr(5'd7, 32'h11); tick();
      chk("starve_force_addr", {27'b0, write_reg_addr}, 32'd7);
      chk("starve_force_data", write_data, 32'h11);
      chk("starve_resume_stall", {31'b0, alu_stall}, 32'd0);
      expect_wr(5'd4, 32'h104); tick();
      alu(1'b0, 5'd0, 32'h0);
      chk("starve_resume_addr", {27'b0, write_reg_addr}, 32'd4);
      tick();

      // FIFO full with ALU held busy; pointers start mid-ring so the fill wraps
      for (int i = 0; i < 4; i++) begin
         chk("fill_lu_ready", {31'b0, lu_ready}, 32'd1);
         lu(1'b1, 5'(16 + i), 32'hA0 + i);
         alu(1'b1, 5'(10 + i), 32'hB0 + i);
         expect_wr(5'(10 + i), 32'hB0 + i);
         tick();
      end
      chk("full_lu_ready", {31'b0, lu_ready}, 32'd0);
      chk("full_force_stall", {31'b0, alu_stall}, 32'd1);
      lu(1'b1, 5'd20, 32'hA4);
      alu(1'b1, 5'd14, 32'hB4);
      expect_wr(5'd16, 32'hA0);
      tick();
      lu(1'b0, 5'd0, 32'h0);
      chk("after_pop_lu_ready", {31'b0, lu_ready}, 32'd1);
      chk("after_pop_stall", {31'b0, alu_stall}, 32'd0);
      expect_wr(5'd14, 32'hB4);
      tick();
      alu(1'b0, 5'd0, 32'h0);
      expect_wr(5'd17, 32'hA1); expect_wr(5'd18, 32'hA2); expect_wr(5'd19, 32'hA3);
      tick(); tick(); tick();
      chk("drain_last_addr", {27'b0, write_reg_addr}, 32'd19);
      tick();
      chk("drained_we", {31'b0, write_enable}, 32'd0);

      // Second fill streaming through, including a dropped x0 result
      lu(1'b1, 5'd21, 32'hC0); expect_wr(5'd21, 32'hC0); tick();
      lu(1'b1, 5'd0, 32'hC1); tick();
      lu(1'b1, 5'd22, 32'hC2); expect_wr(5'd22, 32'hC2); tick();
      lu(1'b1, 5'd23, 32'hC3); expect_wr(5'd23, 32'hC3); tick();
      lu(1'b0, 5'd0, 32'h0);
      tick(); tick();

      // Pending scoreboard
      issue_valid = 1'b1; issue_addr = 5'd9; tick();
      issue_addr = 5'd0; tick();
      issue_valid = 1'b0;
      chk("pend_set9_x0", pending_mask, 32'h0000_0200);
      lu(1'b1, 5'd9, 32'h99); tick();
      lu(1'b0, 5'd0, 32'h0);
      chk("pend_hold_on_push", pending_mask, 32'h0000_0200);
      expect_wr(5'd9, 32'h99); tick();
      chk("pend_clear_on_pop", pending_mask, 32'h0);
      chk("pend_clear_we", {31'b0, write_enable}, 32'd1);
      lu(1'b1, 5'd9, 32'h9A); expect_wr(5'd9, 32'h9A); tick();
      lu(1'b0, 5'd0, 32'h0);
      issue_valid = 1'b1; issue_addr = 5'd9; tick();
      issue_valid = 1'b0;
      chk("pend_set_wins", pending_mask, 32'h0000_0200);
      chk("pend_set_wins_data", write_data, 32'h9A);

      // Reset mid-operation with three buffered entries and pending bits
      for (int i = 0; i < 3; i++) begin
         lu(1'b1, 5'(24 + i), 32'hD0 + i);
         alu(1'b1, 5'(11 + i), 32'hE0 + i);
         expect_wr(5'(11 + i), 32'hE0 + i);
         issue_valid = 1'b1; issue_addr = 5'(5 + i);
         tick();
      end
      lu(1'b0, 5'd0, 32'h0);
      alu(1'b0, 5'd0, 32'h0);
      issue_valid = 1'b0;
      chk("pre_rst_pending", pending_mask, 32'h0000_02E0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_pending", pending_mask, 32'h0);
      chk("mid_rst_we", {31'b0, write_enable}, 32'd0);
      chk("mid_rst_lu_ready", {31'b0, lu_ready}, 32'd1);
      chk("mid_rst_stall", {31'b0, alu_stall}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_idle_we", {31'b0, write_enable}, 32'd0);
      end

      tick(); tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
